// File: rtl/tbl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tbl_seq
// Brief    : Fill sequencer and round-robin read arbiter for the math seed table.
//            Macro TBL_SEQ_AUTOFILL_EN: reset enters FILL instead of IDLE.
// Revision : 1.0
// ============================================================================
module tbl_seq #(
  parameter int NREQ = 2,
  parameter int DW   = 68,
  parameter int NENT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 refill,
  input  logic                 fill_valid,
  output logic                 fill_ready,
  input  logic [7:0]           fill_addr,
  input  logic [DW-1:0]        fill_data,
  output logic                 fill_done,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_A,
  input  logic [NREQ*2-1:0]    req_xtra,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [DW-1:0]        tbl_A,
  output logic [DW-1:0]        tbl_B,
  output logic [1:0]           tbl_xtra,
  output logic                 tbl_is_read,
  output logic                 tbl_is_write,
  input  logic [DW-1:0]        tbl_res
);

  localparam int RRW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW       = 9;
  localparam int ADDR_LSB = 46;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
`ifdef TBL_SEQ_AUTOFILL_EN
  localparam logic [1:0] S_RESET = S_FILL;
`else
  localparam logic [1:0] S_RESET = S_IDLE;
`endif

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic [CW-1:0]   r_cnt;
  logic [RRW-1:0]  r_rr;
  logic [RRW-1:0]  w_gnt_idx;
  logic [NREQ-1:0] w_gnt;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_data;
  logic [DW-1:0]   w_sel_a;
  logic [DW-1:0]   w_fill_b;
  logic [1:0]      w_sel_x;
  logic            w_any;
  logic            w_arb_en;
  logic            w_accept;
  logic            w_last;

  function automatic logic [RRW-1:0] f_slot(input logic [RRW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) s = s - NREQ;
    return RRW'(s);
  endfunction

  assign w_accept = fill_valid && (r_state == S_FILL);
  assign w_last   = w_accept && !refill && (r_cnt == CW'(NENT - 1));
  // refill pre-empts any lookup in the same cycle
  assign w_arb_en = (r_state == S_RUN) && !refill;

  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_arb_en && !w_any && req_valid[f_slot(r_rr, k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = f_slot(r_rr, k);
      end
    end
    if (w_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_x = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = req_A[i*DW +: DW];
        w_sel_x = req_xtra[i*2 +: 2];
      end
    end
  end

  always_comb begin
    w_fill_b = '0;
    w_fill_b[ADDR_LSB +: 8] = fill_addr;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (refill) w_next = S_FILL;
      S_FILL:  if (w_last) w_next = S_RUN;
      S_RUN:   if (refill) w_next = S_FILL;
      default: w_next = S_RESET;
    endcase
  end

  // Output logic
  always_comb begin
    fill_ready   = 1'b0;
    fill_done    = 1'b0;
    req_ready    = '0;
    tbl_A        = '0;
    tbl_B        = '0;
    tbl_xtra     = '0;
    tbl_is_read  = 1'b0;
    tbl_is_write = 1'b0;
    case (r_state)
      S_FILL: begin
        fill_ready = 1'b1;
        if (w_accept) begin
          tbl_is_write = 1'b1;
          tbl_A        = fill_data;
          tbl_B        = w_fill_b;
        end
      end
      S_RUN: begin
        fill_done = 1'b1;
        req_ready = w_gnt;
        if (w_any) begin
          tbl_is_read = 1'b1;
          tbl_A       = w_sel_a;
          tbl_xtra    = w_sel_x;
        end
      end
      default: ;
    endcase
  end

  // Words written during a refill cycle are not counted toward completion
  always_ff @(posedge clk) begin
    if (rst)           r_cnt <= '0;
    else if (refill)   r_cnt <= '0;
    else if (w_accept) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_rr <= '0;
    else if (w_any) r_rr <= f_slot(w_gnt_idx, 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_gnt;
      if (w_any) r_rsp_data <= tbl_res;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_tbl_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbl_seq
// Brief    : Randomized self-checking bench for tbl_seq with a behavioural
//            table memory and round-robin/fill reference model.
// Revision : 1.0
// ============================================================================
module tb_tbl_seq;

  localparam int NREQ = 2;
  localparam int DW   = 68;
  localparam int NENT = 256;

  logic                 clk;
  logic                 rst;
  logic                 refill;
  logic                 fill_valid;
  logic                 fill_ready;
  logic [7:0]           fill_addr;
  logic [DW-1:0]        fill_data;
  logic                 fill_done;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*DW-1:0]   req_A;
  logic [NREQ*2-1:0]    req_xtra;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_data;
  logic [DW-1:0]        tbl_A;
  logic [DW-1:0]        tbl_B;
  logic [1:0]           tbl_xtra;
  logic                 tbl_is_read;
  logic                 tbl_is_write;
  logic [DW-1:0]        tbl_res;

  tbl_seq #(.NREQ(NREQ), .DW(DW), .NENT(NENT)) dut (
    .clk(clk), .rst(rst), .refill(refill),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_done(fill_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_A(req_A), .req_xtra(req_xtra),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tbl_A(tbl_A), .tbl_B(tbl_B), .tbl_xtra(tbl_xtra),
    .tbl_is_read(tbl_is_read), .tbl_is_write(tbl_is_write), .tbl_res(tbl_res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table instance stand-in: write addr in B[53:46], read index {xtra, A[53:48]}
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) if (tbl_is_write) mem[tbl_B[53:46]] <= tbl_A;
  assign tbl_res = mem[{tbl_xtra, tbl_A[53:48]}];

  logic [DW-1:0]   exp_tbl [0:255];
  int              m_rr;
  bit              m_run;
  logic [NREQ-1:0] m_prev_rsp;
  logic            exp_rst_fr;
  int              checks;
  int              failures;

  function automatic logic [DW-1:0] rand_dw();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(m_rr + k) % NREQ]) return (m_rr + k) % NREQ;
    return -1;
  endfunction

  task automatic lookup_cycle(input logic [NREQ-1:0] v, input bit rf, input int force_idx);
    int              g;
    int              idx;
    logic [NREQ-1:0] eg;
    logic [DW-1:0]   ed;
    @(negedge clk);
    req_valid = v;
    refill    = rf;
    for (int i = 0; i < NREQ; i++) begin
      req_A[i*DW +: DW] = rand_dw();
      req_xtra[i*2 +: 2] = 2'($urandom_range(0, 3));
      if (force_idx >= 0) begin
        req_A[i*DW + 48 +: 6] = 6'(force_idx % 64);
        req_xtra[i*2 +: 2]    = 2'(force_idx / 64);
      end
    end
    g  = (m_run && !rf) ? model_grant(v) : -1;
    eg = '0;
    ed = '0;
    if (g >= 0) eg[g] = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== m_prev_rsp)
      $display("FAIL rsp_hold got=%b exp=%b", rsp_valid, m_prev_rsp);
    if (rsp_valid !== m_prev_rsp) failures++;
    checks++;
    if (req_ready !== eg) begin
      failures++;
      $display("FAIL req_ready got=%b exp=%b", req_ready, eg);
    end
    checks++;
    if (tbl_is_read !== (g >= 0)) begin
      failures++;
      $display("FAIL tbl_is_read got=%b exp=%b", tbl_is_read, (g >= 0));
    end
    if (m_run) begin
      checks++;
      if ({fill_ready, fill_done} !== 2'b01) begin
        failures++;
        $display("FAIL run_status got ready/done=%b exp=01", {fill_ready, fill_done});
      end
    end
    if (g >= 0) begin
      idx = int'(req_xtra[g*2 +: 2]) * 64 + int'(req_A[g*DW + 48 +: 6]);
      ed  = exp_tbl[idx];
      checks++;
      if (tbl_A !== req_A[g*DW +: DW] || tbl_xtra !== req_xtra[g*2 +: 2] || tbl_B !== '0) begin
        failures++;
        $display("FAIL tbl_operands got A=%h x=%h exp A=%h x=%h", tbl_A, tbl_xtra,
                 req_A[g*DW +: DW], req_xtra[g*2 +: 2]);
      end
      m_rr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== eg) begin
      failures++;
      $display("FAIL rsp_valid got=%b exp=%b", rsp_valid, eg);
    end
    if (g >= 0) begin
      checks++;
      if (rsp_data !== ed) begin
        failures++;
        $display("FAIL rsp_data got=%h exp=%h", rsp_data, ed);
      end
    end
    m_prev_rsp = eg;
    if (rf) m_run = 1'b0;
    req_valid = '0;
    refill    = 1'b0;
  endtask

  task automatic do_fill(input int n, input bit rnd);
    int            acc;
    int            cyc;
    int            addr;
    logic [DW-1:0] d;
    logic [DW-1:0] exp_b;
    @(negedge clk);
    refill     = 1'b1;
    fill_valid = 1'b0;
    req_valid  = '0;
    @(posedge clk);
    #1;
    refill     = 1'b0;
    m_run      = 1'b0;
    m_prev_rsp = '0;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 8 * n + 16) begin
      @(negedge clk);
      cyc++;
      fill_valid = ($urandom_range(0, 3) != 0);
      addr       = rnd ? (255 - acc) : acc;
      fill_addr  = 8'(addr);
      d          = rnd ? rand_dw() : DW'(acc * 3);
      fill_data  = d;
      #1;
      checks++;
      if (fill_ready !== 1'b1 || fill_done !== 1'b0) begin
        failures++;
        $display("FAIL fill_status at word %0d got ready/done=%b exp=10", acc, {fill_ready, fill_done});
      end
      checks++;
      if (tbl_is_write !== fill_valid || tbl_is_read !== 1'b0) begin
        failures++;
        $display("FAIL fill_strobe got wr/rd=%b exp=%b0", {tbl_is_write, tbl_is_read}, fill_valid);
      end
      if (fill_valid) begin
        exp_b = '0;
        exp_b[53:46] = fill_addr;
        checks++;
        if (tbl_A !== d || tbl_B !== exp_b) begin
          failures++;
          $display("FAIL fill_operands got A=%h B=%h exp A=%h B=%h", tbl_A, tbl_B, d, exp_b);
        end
      end
      @(posedge clk);
      #1;
      if (fill_valid) begin
        exp_tbl[addr] = d;
        acc++;
      end
      fill_valid = 1'b0;
    end
    checks++;
    if (acc < n) begin
      failures++;
      $display("FAIL fill_timeout accepted=%0d required=%0d", acc, n);
    end
    if (n == NENT) begin
      checks++;
      if (fill_done !== 1'b1 || fill_ready !== 1'b0) begin
        failures++;
        $display("FAIL fill_complete got ready/done=%b exp=01", {fill_ready, fill_done});
      end
      m_run = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '1; fill_valid = 1'b1; refill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (fill_ready !== exp_rst_fr || fill_done !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_ctrl got ready/done/req_ready=%b/%b/%b", fill_ready, fill_done, req_ready);
    end
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0 || tbl_is_read !== 1'b0 || tbl_xtra !== '0) begin
      failures++;
      $display("FAIL reset_rsp got rsp_valid=%b rsp_data=%h rd=%b", rsp_valid, rsp_data, tbl_is_read);
    end
    @(negedge clk);
    rst = 1'b0; fill_valid = 1'b0;
    #1;
    checks++;
    if (fill_ready !== exp_rst_fr || req_ready !== '0 || tbl_is_write !== 1'b0) begin
      failures++;
      $display("FAIL post_reset got fill_ready=%b req_ready=%b exp fill_ready=%b", fill_ready, req_ready, exp_rst_fr);
    end
    req_valid  = '0;
    m_rr       = 0;
    m_run      = 1'b0;
    m_prev_rsp = '0;
  endtask

  task automatic test_fill();
    do_fill(NENT, 1'b0);
  endtask

  task automatic test_single();
    lookup_cycle(2'b01, 1'b0, 5);
    checks++;
    if (rsp_data !== DW'(15)) begin
      failures++;
      $display("FAIL single_word5 got=%h exp=%h", rsp_data, DW'(15));
    end
  endtask

  task automatic test_contention();
    lookup_cycle(2'b10, 1'b0, -1);
    repeat (4) lookup_cycle(2'b11, 1'b0, -1);
  endtask

  task automatic test_random(input int n);
    for (int c = 0; c < n; c++) lookup_cycle(NREQ'($urandom()), 1'b0, -1);
  endtask

  task automatic test_refill_run();
    lookup_cycle(2'b01, 1'b0, -1);
    lookup_cycle(2'b11, 1'b1, -1);
    checks++;
    if (fill_done !== 1'b0 || fill_ready !== 1'b1) begin
      failures++;
      $display("FAIL refill_run got ready/done=%b exp=10", {fill_ready, fill_done});
    end
    do_fill(NENT, 1'b1);
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    req_valid = 2'b01; req_A = {NREQ{rand_dw()}}; rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== '0 || rsp_data !== '0 || req_ready !== '0 || fill_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_lookup got rsp_valid=%b rsp_data=%h req_ready=%b done=%b",
               rsp_valid, rsp_data, req_ready, fill_done);
    end
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    m_rr = 0; m_run = 1'b0; m_prev_rsp = '0;
    do_fill(100, 1'b1);
    @(negedge clk);
    rst = 1'b1; fill_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (fill_ready !== exp_rst_fr || fill_done !== 1'b0 || tbl_is_read !== 1'b0) begin
      failures++;
      $display("FAIL rst_fill got ready/done=%b/%b exp %b/0", fill_ready, fill_done, exp_rst_fr);
    end
    @(negedge clk);
    rst = 1'b0; fill_valid = 1'b0;
    do_fill(NENT, 1'b1);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; refill = 1'b0; fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
    req_valid = '0; req_A = '0; req_xtra = '0;
    m_rr = 0; m_run = 1'b0; m_prev_rsp = '0;
`ifdef TBL_SEQ_AUTOFILL_EN
    exp_rst_fr = 1'b1;
`else
    exp_rst_fr = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      exp_tbl[i] = '0;
    end
    test_reset();
    test_fill();
    test_single();
    test_contention();
    test_random(200);
    test_refill_run();
    test_random(100);
    test_rst_mid();
    test_random(100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
